// File: rtl/usb_tx_pkg.sv
// USB transmit controller shared definitions.
// State encoding, SYNC pattern and default timing parameters.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_e;

  localparam logic [7:0] SYNC_PATTERN    = 8'h80;
  localparam int         STUFF_LEN_DEF   = 6;
  localparam int         EOP_SE0_CYC_DEF = 2;

endpackage

// File: rtl/usb_tx_ctrl_stuff_counter.sv
// Consecutive-ones counter for USB bit stuffing.
// stuff_next flags that the bit going out now completes a run.
module stuff_counter #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst_L,
  input  logic data_bit,
  input  logic enable,
  input  logic clear,
  output logic stuff_next
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] TERM = CW'(STUFF_LEN);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (!data_bit)
        cnt <= '0;
      else if (cnt != TERM)
        cnt <= cnt + 1'b1;
    end
  end

  assign stuff_next = enable & data_bit
                    & (cnt == TERM - 1'b1);

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB low-level transmit sequencer: SYNC, stuffed
// LSB-first data, then SE0/J end-of-packet.
import usb_tx_pkg::*;

module usb_tx_ctrl #(
  parameter int STUFF_LEN   = STUFF_LEN_DEF,
  parameter int EOP_SE0_CYC = EOP_SE0_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_byte,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic       nrz_bit,
  output logic       nrzi_start,
  output logic       nrzi_end,
  output logic       se0,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_CYC - 1);

  state_e     state, nxt;
  logic [2:0] bidx;
  logic [7:0] sr, hold, src;
  logic       hold_vld, hold_last, cur_last;
  logic       stuff_q, fin_q;
  logic       stuff_next, cnt_en, emit;
  logic       rdy, accept, fin, reload;

  stuff_counter #(.STUFF_LEN(STUFF_LEN)) u_stuff (
    .clk        (clk),
    .rst_L      (rst_L),
    .data_bit   (nrz_bit),
    .enable     (cnt_en),
    .clear      (state == IDLE),
    .stuff_next (stuff_next)
  );

  // Line outputs; a freshly accepted byte is read straight from hold.
  always_comb begin
    nrz_bit    = 1'b1;
    se0        = 1'b0;
    nrzi_start = 1'b0;
    nrzi_end   = 1'b0;
    cnt_en     = 1'b0;
    emit       = 1'b0;
    src        = hold_vld ? hold : sr;
    unique case (state)
      SYNC: begin
        nrz_bit    = SYNC_PATTERN[bidx];
        nrzi_start = (bidx == 3'd0);
        cnt_en     = 1'b1;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (stuff_q) begin
          nrz_bit = 1'b0;
        end else begin
          nrz_bit = src[0];
          emit    = 1'b1;
        end
      end
      EOP_SE0: begin
        se0      = 1'b1;
        nrzi_end = (bidx == 3'd0);
      end
      default: ;
    endcase
  end

  assign reload = emit & (bidx == 3'd7) & ~cur_last;
  assign fin    = emit & (bidx == 3'd7)
                & (cur_last | ~pkt_valid);

  always_comb begin
    nxt         = state;
    rdy         = 1'b0;
    accept      = 1'b0;
    tx_underrun = 1'b0;
    unique case (state)
      IDLE: begin
        rdy    = 1'b1;
        accept = pkt_valid;
        if (pkt_valid) nxt = SYNC;
      end
      SYNC: begin
        if (bidx == 3'd7) nxt = DATA;
      end
      DATA: begin
        rdy         = reload;
        accept      = reload & pkt_valid;
        tx_underrun = reload & ~pkt_valid;
        if (stuff_q && fin_q) nxt = EOP_SE0;
        if (fin && !stuff_next) nxt = EOP_SE0;
      end
      EOP_SE0: begin
        if (bidx == SE0_LAST) nxt = EOP_J;
      end
      EOP_J: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign pkt_ready = rdy & rst_L;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= IDLE;
      bidx      <= '0;
      sr        <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      hold_last <= 1'b0;
      cur_last  <= 1'b0;
      stuff_q   <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state   <= nxt;
      stuff_q <= stuff_next;
      if (nxt != state)
        bidx <= '0;
      else if (state == SYNC || state == EOP_SE0 || emit)
        bidx <= (bidx == 3'd7) ? 3'd0 : bidx + 3'd1;
      if (accept) begin
        hold      <= pkt_byte;
        hold_last <= pkt_last;
        hold_vld  <= 1'b1;
      end else if (emit) begin
        hold_vld  <= 1'b0;
      end
      if (emit) begin
        sr <= {1'b0, src[7:1]};
        if (hold_vld) cur_last <= hold_last;
      end
      fin_q <= (state == IDLE) ? 1'b0 : (fin_q | fin);
    end
  end

endmodule

// File: doc/usb_tx_ctrl.md
USB_TX_CTRL -- requirements
Module: usb_tx_ctrl

Interface
REQ-001 SHALL have parameter STUFF_LEN, default 6: the number of consecutive 1s after which a 0 is stuffed.
REQ-002 SHALL have parameter EOP_SE0_CYC, default 2: the number of SE0 cycles in an EOP.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on posedge.
REQ-004 SHALL have port rst_L, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pkt_valid, input, 1: pkt_byte and pkt_last are valid.
REQ-006 SHALL have port pkt_byte, input, 8: packet byte, sent LSB first.
REQ-007 SHALL have port pkt_last, input, 1: this byte is the final byte of the packet.
REQ-008 SHALL have port pkt_ready, output, 1: a byte is accepted on a cycle where pkt_valid & pkt_ready.
REQ-009 SHALL have port nrz_bit, output, 1: unencoded bit to the NRZI encoder's inb.
REQ-010 SHALL have port nrzi_start, output, 1: one-cycle pulse to the encoder's data_start.
REQ-011 SHALL have port nrzi_end, output, 1: one-cycle pulse to the encoder's data_end.
REQ-012 SHALL have port se0, output, 1: the line driver forces SE0.
REQ-013 SHALL have port tx_busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port tx_underrun, output, 1: one-cycle error pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, SYNC, DATA, EOP_SE0 and EOP_J.
REQ-016 In IDLE: pkt_ready=1, nrz_bit=1, se0=0; on accept, the FSM SHALL enter SYNC, with the first SYNC bit on the next cycle.
REQ-017 SYNC SHALL last 8 cycles and emit 0,0,0,0,0,0,0,1; nrzi_start SHALL be high only in the first SYNC cycle.
REQ-018 DATA SHALL emit one bit per cycle, LSB first, from a shift register.
REQ-019 The ones-counter SHALL count consecutive 1s on nrz_bit, including the final SYNC 1, and SHALL clear on any 0.
REQ-020 When the count reaches STUFF_LEN, the next cycle SHALL emit a stuffed 0 without advancing the bit index; the count SHALL then clear.
REQ-021 The ones-count SHALL carry across byte boundaries.
REQ-022 pkt_ready SHALL be 1 in the cycle bit 7 of a non-last byte is emitted; the accepted byte SHALL go to a holding register.
REQ-023 After bit 7, a pending stuff bit SHALL be emitted first; then bit 0 of the held byte SHALL follow.
REQ-024 If pkt_valid=0 in the bit-7 reload cycle, tx_underrun SHALL pulse that cycle.
REQ-025 On underrun, the block SHALL finish any pending stuff bit and then enter EOP_SE0.
REQ-026 After bit 7 of the last byte, including any required stuff bit, the FSM SHALL enter EOP_SE0.
REQ-027 EOP_SE0 SHALL last EOP_SE0_CYC cycles with se0=1 and nrz_bit=1; nrzi_end SHALL be high in the first of these cycles only.
REQ-028 EOP_J SHALL last 1 cycle with se0=0 and nrz_bit=1 (J), then go to IDLE.
REQ-029 pkt_ready SHALL be 0 in SYNC, EOP_SE0 and EOP_J, and in DATA outside the reload cycle.
REQ-030 Back-to-back packets SHALL have at least 1 IDLE cycle between the EOP_J cycle and the next SYNC.
REQ-031 Bit and cycle counters SHALL be 3 bits (bit index) and ceil(log2(STUFF_LEN+1)) bits (ones count); they SHALL NOT wrap beyond their terminal values.

Reset
REQ-032 While rst_L=0, outputs SHALL be: pkt_ready=0, nrz_bit=1, nrzi_start=0, nrzi_end=0, se0=0, tx_busy=0, tx_underrun=0; state SHALL be IDLE; counters and registers SHALL be 0.
REQ-033 Reset asserted mid-packet SHALL abort immediately: no EOP, no nrzi_end pulse, and the held byte is discarded.

Structure
REQ-034 Package usb_tx_pkg SHALL hold: the state enum; SYNC_PATTERN = 8'h80; default STUFF_LEN and EOP_SE0_CYC.
REQ-035 The ones-counter and stuff decision SHALL be a sub-module named stuff_counter (inputs: bit, enable, clear; output: stuff_next).

Verification
REQ-036 Send byte 0x00 with last=1 -> 0000000 1, then 00000000, SE0 for 2 cycles, J; tx_busy high for exactly 19 cycles.
REQ-037 Send byte 0xFF with last=1 -> data stream 11111 0 111, then EOP; 9 data cycles.
REQ-038 Send 0xFF, 0xFF with valid held high -> stuffed 0 after data bits 5 and 11; 18 data cycles; pkt_ready pulses once at the first byte's bit 7.
REQ-039 Send 2-byte packet with pkt_valid low at byte0 bit 7 -> tx_underrun pulses 1 cycle; EOP_SE0 follows the next cycle.
REQ-040 Drop rst_L during DATA bit 3 -> all outputs take reset values at once; nrzi_end never pulses; after release, a new packet sends a normal SYNC.
REQ-041 Hold pkt_valid high across the end of a packet -> next nrzi_start occurs no earlier than 2 cycles after EOP_J.
